display_scanner: RTL
====================

DISPLAY_SCANNER -- requirements
Module: display_scanner

Interface
REQ-001 Parameter NUM_DIGITS, default 4, number of multiplexed 7-segment digits; legal range 1..8.
REQ-002 Parameter PRESCALE, default 50000, clk cycles per digit slot; legal minimum 2.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 value_in  input  4*NUM_DIGITS  hex value to display; nibble k drives digit k, digit 0 least significant.
REQ-006 load  input  1  one-cycle request to capture value_in.
REQ-007 blank_lz  input  1  1 = blank leading zero digits.
REQ-008 nibble  output  4  hex code of the active digit, fed to the 7-segment decoder input.
REQ-009 an  output  NUM_DIGITS  active-low digit enables; at most one bit low at any time.
REQ-010 digit_idx  output  3  index of the current digit slot.
REQ-011 frame_done  output  1  one-cycle pulse at the end of each full scan.
REQ-012 pending  output  1  high while a captured value waits for a frame boundary.

Function
REQ-013 All outputs SHALL be registered.
REQ-014 Prescaler cnt SHALL count 0..PRESCALE-1 and wrap to 0; tick = (cnt == PRESCALE-1).
REQ-015 On a tick, digit_idx SHALL advance by 1 and wrap from NUM_DIGITS-1 to 0; with NUM_DIGITS=1 it stays 0.
REQ-016 A dead cycle SHALL follow every tick: an = all ones for exactly the clk cycle after the tick edge, then the new digit's enable bit goes low.
REQ-017 nibble SHALL equal disp_reg nibble digit_idx, updated on the same edge as digit_idx.
REQ-018 load=1 SHALL capture value_in into pend_reg and set pending=1; a later load before the boundary overwrites pend_reg (last load wins).
REQ-019 Frame boundary = tick edge where digit_idx wraps NUM_DIGITS-1 -> 0; at it, if pending=1, disp_reg <= pend_reg and pending <= 0.
REQ-020 load coincident with the boundary edge SHALL write value_in directly to disp_reg and leave pending=0 (no extra frame of delay).
REQ-021 frame_done SHALL be high for exactly one cycle, the cycle after each boundary edge.
REQ-022 disp_reg SHALL change only at a frame boundary; no frame may mix digits from two values.
REQ-023 With blank_lz=1, a digit k>0 SHALL be blanked (its an bit held high during its slot) when disp_reg nibbles k..NUM_DIGITS-1 are all zero; digit 0 is never blanked; nibble still outputs 4'h0.
REQ-024 blank_lz is sampled every cycle; a change takes effect from the next cycle.
REQ-025 Slot timing: each digit enabled PRESCALE-1 cycles per slot; frame period NUM_DIGITS*PRESCALE cycles.

Reset
REQ-026 While rst=1: cnt=0, digit_idx=0, disp_reg=0, pend_reg=0, pending=0, nibble=4'h0, an=all ones, frame_done=0.
REQ-027 First cycle after rst release SHALL be a dead cycle; an[0]=0 from the second cycle.
REQ-028 rst mid-frame SHALL abort the scan and discard any pending value; scanning restarts at digit 0.

Verification (NUM_DIGITS=4, PRESCALE=4)
REQ-029 Reset release, no load -> an sequence 1111, then 1110 x3 cycles, 1111, 1101 x3, ...; nibble=0; frame_done pulses every 16 cycles.
REQ-030 load with value_in=16'h12AF mid-frame -> pending=1; display unchanged until boundary; next frame nibble sequence F,A,2,1; pending=0.
REQ-031 loads 16'h1111 then 16'h2222 in one frame -> next frame shows 2,2,2,2 only.
REQ-032 load of 16'h00B0 exactly on boundary edge -> following frame shows 0,B,0,0; pending never rises.
REQ-033 blank_lz=1, disp=16'h0070 -> an low for digits 0,1 only; digits 2,3 slots all ones; blank_lz=0 restores all four.
REQ-034 rst pulse while pending=1 at digit 2 -> all outputs return to REQ-026 values; old pending value never displayed.

Source files
------------

// File: rtl/display_scanner.sv
// rtl/display_scanner.sv - multiplexed 7-segment digit scanner with frame-synchronous value update
//
// Purpose: steps through NUM_DIGITS digit slots of PRESCALE clk cycles each.
// The digit enable is held off for one dead cycle at the start of every slot.
// A newly loaded value is committed to the display only at a frame boundary,
// so a scan never shows digits from two different values.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   value_in   in   [4*NUM_DIGITS] hex value, nibble k -> digit k
//   load       in   one-cycle capture request for value_in
//   blank_lz   in   1 = blank leading zero digits (digit 0 never blanked)
//   nibble     out  [4] hex code of the active digit
//   an         out  [NUM_DIGITS] active-low digit enables
//   digit_idx  out  [3] current digit slot
//   frame_done out  one-cycle pulse after each frame boundary
//   pending    out  captured value waiting for the next frame boundary
module display_scanner #(
  parameter int NUM_DIGITS = 4,
  parameter int PRESCALE   = 50000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic                    load,
  input  logic                    blank_lz,
  output logic [3:0]              nibble,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [2:0]              digit_idx,
  output logic                    frame_done,
  output logic                    pending
);

  localparam int CW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(PRESCALE - 1);
  localparam logic [2:0]    LAST_IDX = 3'(NUM_DIGITS - 1);

  logic [CW-1:0]           cnt;
  logic [4*NUM_DIGITS-1:0] disp_reg;
  logic [4*NUM_DIGITS-1:0] pend_reg;

  logic                    tick;
  logic                    boundary;
  logic [2:0]              idx_next;
  logic [4*NUM_DIGITS-1:0] disp_next;
  logic [3:0]              nibble_next;
  logic [NUM_DIGITS-1:0]   blank;
  logic [NUM_DIGITS-1:0]   an_next;
  logic                    zero_above;

  always_comb begin
    tick     = (cnt == CNT_MAX);
    boundary = tick && (digit_idx == LAST_IDX);

    idx_next = digit_idx;
    if (tick) begin
      idx_next = (digit_idx == LAST_IDX) ? 3'd0 : digit_idx + 3'd1;
    end

    // A load on the boundary edge bypasses pend_reg so it shows this frame.
    disp_next = disp_reg;
    if (boundary) begin
      if (load) begin
        disp_next = value_in;
      end else if (pending) begin
        disp_next = pend_reg;
      end
    end

    // nibble follows digit_idx on the same edge, including a boundary swap.
    nibble_next = 4'h0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (k == int'(idx_next)) begin
        nibble_next = disp_next[4*k +: 4];
      end
    end

    // blank[k]: nibbles k..top of the displayed value are all zero.
    blank      = '0;
    zero_above = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      if (disp_reg[4*k +: 4] != 4'h0) begin
        zero_above = 1'b0;
      end
      blank[k] = zero_above;
    end

    // The tick edge always produces an all-off dead cycle.
    an_next = '1;
    if (!tick) begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        if ((k == int'(digit_idx)) && !(blank_lz && blank[k])) begin
          an_next[k] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      digit_idx  <= 3'd0;
      disp_reg   <= '0;
      pend_reg   <= '0;
      pending    <= 1'b0;
      nibble     <= 4'h0;
      an         <= '1;
      frame_done <= 1'b0;
    end else begin
      cnt        <= tick ? '0 : cnt + 1'b1;
      digit_idx  <= idx_next;
      disp_reg   <= disp_next;
      nibble     <= nibble_next;
      an         <= an_next;
      frame_done <= boundary;
      if (boundary) begin
        pending <= 1'b0;
      end else if (load) begin
        pend_reg <= value_in;
        pending  <= 1'b1;
      end
    end
  end

endmodule
